// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the staged reset sequencer.
package lynx_rst_pkg;

    typedef enum logic [1:0] {
        LOCKWAIT = 2'd0,
        HOLD     = 2'd1,
        RELEASE  = 2'd2,
        RUN      = 2'd3
    } rst_state_e;

    // Cause bit positions for the default source count (NSRC = 4).
    localparam int NSRC_DEF   = 4;
    localparam int CAUSE_MODE = NSRC_DEF;
    localparam int CAUSE_LOCK = NSRC_DEF + 1;

    // Bits needed for a counter that must hold values 0..max_val.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Bundle of reset requests in and staged resets/status out.
interface reset_sequencer_if #(
    parameter int NSRC   = 4,
    parameter int MODE_W = 2,
    parameter int NOUT   = 2
);
    logic                pll_locked;
    logic [NSRC-1:0]     req_i;
    logic [MODE_W-1:0]   mode_i;
    logic [NOUT-1:0]     reset_o;
    logic                ready_o;
    logic [MODE_W-1:0]   mode_o;
    logic [NSRC+1:0]     cause_o;

    modport master (
        output pll_locked, req_i, mode_i,
        input  reset_o, ready_o, mode_o, cause_o
    );

    modport slave (
        input  pll_locked, req_i, mode_i,
        output reset_o, ready_o, mode_o, cause_o
    );
endinterface

// File: rtl/reset_sequencer_sync2.sv
// Two-flop synchroniser for a vector of independent asynchronous bits.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= d;
            r_s2 <= r_s1;
        end
    end

    assign q = r_s2;
endmodule

// File: rtl/reset_sequencer.sv
// Filters PLL lock, watches reset requests and mode changes, holds all resets
// for a minimum time, then releases reset domains one after another.
module reset_sequencer
    import lynx_rst_pkg::*;
#(
    parameter int NSRC      = 4,
    parameter int MODE_W    = 2,
    parameter int LOCK_FILT = 16,
    parameter int HOLD_CYC  = 1024,
    parameter int NOUT      = 2,
    parameter int STAGE_GAP = 64
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    reset_sequencer_if.slave bus
);
    localparam int CW        = NSRC + 2;
    localparam int C_MODE    = NSRC;
    localparam int C_LOCK    = NSRC + 1;
    localparam int LOCK_W    = cnt_w(LOCK_FILT);
    localparam int HOLD_W    = cnt_w(HOLD_CYC - 1);
    localparam int STAGE_MAX = (NOUT - 1) * STAGE_GAP;
    localparam int STAGE_W   = cnt_w(STAGE_MAX);

    rst_state_e          r_state;
    logic [LOCK_W-1:0]   r_lock_cnt;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [STAGE_W-1:0]  r_stage_cnt;
    logic [NOUT-1:0]     r_reset;
    logic                r_ready;
    logic [MODE_W-1:0]   r_mode;
    logic [CW-1:0]       r_cause;

    logic [NSRC:0]       w_sync_in;
    logic [NSRC:0]       w_sync_out;
    logic                w_lk;
    logic [NSRC-1:0]     w_rq;
    logic                w_mode_chg;
    logic [CW-1:0]       w_ev_bits;
    logic                w_event;
    logic                w_restart;
    logic [LOCK_W-1:0]   w_lock_inc;
    logic [HOLD_W-1:0]   w_hold_inc;
    logic [STAGE_W-1:0]  w_stage_nxt;
    logic [NOUT-1:0]     w_stage_hit;

    assign w_sync_in = {bus.pll_locked, bus.req_i};

    sync2 #(.W(NSRC + 1)) u_sync (
        .clk   (clk_sys),
        .rst_n (reset_n),
        .d     (w_sync_in),
        .q     (w_sync_out)
    );

    assign w_lk       = w_sync_out[NSRC];
    assign w_rq       = w_sync_out[NSRC-1:0];
    assign w_mode_chg = (bus.mode_i != r_mode);

    always_comb begin
        w_ev_bits         = '0;
        w_ev_bits[NSRC-1:0] = w_rq;
        w_ev_bits[C_MODE] = w_mode_chg;
        w_ev_bits[C_LOCK] = ~w_lk;
    end

    assign w_event   = |w_ev_bits;
    assign w_restart = w_event && (r_state == RELEASE || r_state == RUN);

    // Saturating increments: counters stop at their maximum instead of wrapping.
    assign w_lock_inc  = (r_lock_cnt == LOCK_W'(LOCK_FILT)) ? r_lock_cnt : r_lock_cnt + 1'b1;
    assign w_hold_inc  = (r_hold_cnt == HOLD_W'(HOLD_CYC - 1)) ? r_hold_cnt : r_hold_cnt + 1'b1;
    assign w_stage_nxt = (r_stage_cnt == STAGE_W'(STAGE_MAX)) ? r_stage_cnt : r_stage_cnt + 1'b1;

    // Stage k drops when the stage counter is about to equal k*STAGE_GAP.
    genvar gi;
    generate
        for (gi = 0; gi < NOUT; gi = gi + 1) begin : g_stage
            assign w_stage_hit[gi] = (gi != 0) && (w_stage_nxt == STAGE_W'(gi * STAGE_GAP));
        end
    endgenerate

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= LOCKWAIT;
            r_lock_cnt  <= '0;
            r_hold_cnt  <= '0;
            r_stage_cnt <= '0;
            r_reset     <= '1;
            r_ready     <= 1'b0;
            r_mode      <= '0;
            r_cause     <= '0;
        end else begin
            // Cause is frozen in RUN and restarts from the exit event.
            if (r_state == RUN) begin
                if (w_event) r_cause <= w_ev_bits;
            end else begin
                r_cause <= r_cause | w_ev_bits;
            end

            if (w_restart) begin
                r_reset    <= '1;
                r_ready    <= 1'b0;
                r_hold_cnt <= '0;
                r_lock_cnt <= '0;
                r_mode     <= bus.mode_i;
                r_state    <= w_lk ? HOLD : LOCKWAIT;
            end else begin
                case (r_state)
                    LOCKWAIT: begin
                        if (!w_lk) begin
                            r_lock_cnt <= '0;
                        end else begin
                            r_lock_cnt <= w_lock_inc;
                            if (r_lock_cnt >= LOCK_W'(LOCK_FILT - 1)) begin
                                r_state    <= HOLD;
                                r_mode     <= bus.mode_i;
                                r_hold_cnt <= '0;
                            end
                        end
                    end
                    HOLD: begin
                        r_reset <= '1;
                        if (!w_lk) begin
                            r_state    <= LOCKWAIT;
                            r_lock_cnt <= '0;
                        end else if ((|w_rq) || w_mode_chg) begin
                            r_hold_cnt <= '0;
                            r_mode     <= bus.mode_i;
                        end else if (r_hold_cnt == HOLD_W'(HOLD_CYC - 1)) begin
                            r_reset[0]  <= 1'b0;
                            r_stage_cnt <= '0;
                            if (NOUT == 1) begin
                                r_state <= RUN;
                                r_ready <= 1'b1;
                            end else begin
                                r_state <= RELEASE;
                            end
                        end else begin
                            r_hold_cnt <= w_hold_inc;
                        end
                    end
                    RELEASE: begin
                        r_stage_cnt <= w_stage_nxt;
                        r_reset     <= r_reset & ~w_stage_hit;
                        if (w_stage_hit[NOUT-1]) begin
                            r_state <= RUN;
                            r_ready <= 1'b1;
                        end
                    end
                    RUN: begin
                        r_ready <= 1'b1;
                    end
                    default: begin
                        r_state <= LOCKWAIT;
                    end
                endcase
            end
        end
    end

    assign bus.reset_o = r_reset;
    assign bus.ready_o = r_ready;
    assign bus.mode_o  = r_mode;
    assign bus.cause_o = r_cause;

endmodule
